// File: rtl/upc_scan_controller.sv
// UPC scanner front end: synchronises switches and push-buttons, captures a code per scan press
// and holds it on the HEX decoder bus for a fixed display window.
module upc_scan_controller #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       upc_sw,
  input  logic             scan_key,
  input  logic             clear_key,
  output logic [3:0]       bcd,
  output logic             showing,
  output logic             unknown,
  output logic [CNT_W-1:0] scan_count
);

  localparam int            TW    = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] TLOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    BLANK = 4'hF;

  typedef enum logic {IDLE, SHOW} state_t;

  logic [3:0]       swMeta_q, swSync_q, swCap_q;
  logic             scanMeta_q, scanSync_q, scanPrev_q, scanArmed_q, scanPulse_q;
  logic             clearMeta_q, clearSync_q, clearPrev_q, clearArmed_q, clearPulse_q;
  logic [1:0]       flush_q;
  state_t           state_q;
  logic [3:0]       bcd_q;
  logic             showing_q, unknown_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TW-1:0]    timer_q;

  logic flushDone, scanPress_d, clearPress_d, capture, blankNow, capKnown;

  function automatic logic codeKnown(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // A key is only armed once a genuine released level has crossed the synchroniser after reset,
  // so a key held low through reset release cannot masquerade as a press.
  always_comb begin
    flushDone    = (flush_q == 2'd2);
    scanPress_d  = scanArmed_q & scanPrev_q & ~scanSync_q;
    clearPress_d = clearArmed_q & clearPrev_q & ~clearSync_q;
    capture      = scanPulse_q & ~clearPulse_q;
    blankNow     = (state_q == SHOW) &
                   (clearPulse_q | (~scanPulse_q & (timer_q == '0)));
    capKnown     = codeKnown(swCap_q);
    count_d      = (count_q == '1) ? count_q : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      swMeta_q     <= '0;
      swSync_q     <= '0;
      swCap_q      <= '0;
      scanMeta_q   <= 1'b1;
      scanSync_q   <= 1'b1;
      scanPrev_q   <= 1'b1;
      scanArmed_q  <= 1'b0;
      scanPulse_q  <= 1'b0;
      clearMeta_q  <= 1'b1;
      clearSync_q  <= 1'b1;
      clearPrev_q  <= 1'b1;
      clearArmed_q <= 1'b0;
      clearPulse_q <= 1'b0;
      flush_q      <= 2'd0;
    end else begin
      swMeta_q     <= upc_sw;
      swSync_q     <= swMeta_q;
      swCap_q      <= swSync_q;
      scanMeta_q   <= scan_key;
      scanSync_q   <= scanMeta_q;
      scanPrev_q   <= scanSync_q;
      scanPulse_q  <= scanPress_d;
      clearMeta_q  <= clear_key;
      clearSync_q  <= clearMeta_q;
      clearPrev_q  <= clearSync_q;
      clearPulse_q <= clearPress_d;
      if (!flushDone) flush_q <= flush_q + 2'd1;
      if (flushDone && scanSync_q) scanArmed_q <= 1'b1;
      if (flushDone && clearSync_q) clearArmed_q <= 1'b1;
    end
  end

  // Display FSM; clear beats a coincident scan, and a rescan in SHOW restarts the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      bcd_q     <= BLANK;
      showing_q <= 1'b0;
      unknown_q <= 1'b0;
      count_q   <= '0;
      timer_q   <= '0;
    end else if (capture) begin
      state_q   <= SHOW;
      bcd_q     <= swCap_q;
      showing_q <= 1'b1;
      unknown_q <= ~capKnown;
      timer_q   <= TLOAD;
      if (capKnown) count_q <= count_d;
    end else if (blankNow) begin
      state_q   <= IDLE;
      bcd_q     <= BLANK;
      showing_q <= 1'b0;
      unknown_q <= 1'b0;
    end else if (state_q == SHOW) begin
      timer_q <= timer_q - 1'b1;
    end
  end

  assign bcd        = bcd_q;
  assign showing    = showing_q;
  assign unknown    = unknown_q;
  assign scan_count = count_q;

endmodule

// File: doc/upc_scan_controller.md
# upc_scan_controller

Front-end stage of the UPC checker. Synchronises the raw UPC switches and the scan/clear push-buttons, captures a UPC code on each scan press, and holds it on the 4-bit `bcd` bus that drives the item-name HEX decoder for a fixed display window. Outside the window it drives the blank code, which the decoder renders as all segments off. It also flags codes the decoder does not recognise and counts accepted scans.

## Interface
- `HOLD_CYCLES`, default 50_000_000: display window length in clock cycles, 1 s at 50 MHz. Legal range ≥ 2.
- `CNT_W`, default 8: width of `scan_count`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `upc_sw` in 4: raw UPC switches (asynchronous).
- `scan_key` in 1: raw scan button, active-low (0 = pressed), asynchronous.
- `clear_key` in 1: raw clear button, active-low, asynchronous.
- `bcd` out 4: code to the HEX decoder; 4'b1111 = blank.
- `showing` out 1: high while a code is being displayed.
- `unknown` out 1: high while showing a code outside {0,1,3,4,5,6}.
- `scan_count` out CNT_W: number of accepted scans of known codes, saturating.

## Operation
- Synchronisers: `upc_sw`, `scan_key`, `clear_key` each pass through 2 flops. Key flops reset to 1 (released); switch flops reset to 0.
- Press detect: a third flop holds the previous synced key value. `scan_p` = prev 1 & synced 0, one cycle per press. `clear_p` is formed the same way. Holding a key produces no repeats. A release generates nothing.
- FSM states:
  - IDLE: `bcd` = 4'hF, `showing` = 0, `unknown` = 0.
    - `scan_p` & !`clear_p` → SHOW. Latch synced `upc_sw` into `bcd`. Load timer with HOLD_CYCLES-1.
  - SHOW: `bcd` holds the latched code, `showing` = 1.
    - `clear_p` → IDLE; takes priority over `scan_p` in the same cycle.
    - else `scan_p` → stay in SHOW. Relatch the code and reload the timer (the window restarts).
    - else timer == 0 → IDLE.
    - else timer decrements.
- `unknown` = `showing` & (latched code ∉ {0,1,3,4,5,6}). It is registered together with `bcd`.
- Scan count rules:
  - `scan_count` increments by 1 on each accepted scan whose captured code is known. Unknown scans and scans suppressed by `clear_p` do not count.
  - It saturates at 2^CNT_W-1 with no wrap.
  - `clear_p` does not reset it; only `reset` does.
- Code 4'hF captured from the switches counts as unknown. `bcd` still shows 4'hF, so the display is blank while `showing` = 1 and `unknown` = 1.
- Timer width: $clog2(HOLD_CYCLES).

## Timing
- Reset values (sampled low on a rising edge): state IDLE, `bcd` = 4'hF, `showing` = 0, `unknown` = 0, `scan_count` = 0, timer 0, prev/sync key flops 1, sync switch flops 0.
  - Reset mid-SHOW blanks the display on the next edge.
  - A key held low through reset release is not a press until it is released and pressed again.
- Latency: a key low at rising edge N (and `reset` high) makes `bcd`, `showing`, `unknown` and `scan_count` update at edge N+3. Switch values are taken from the same synced sample, so switches must be stable from edge N-1 to edge N+1.
- Window: `showing` stays high for exactly HOLD_CYCLES cycles after the capturing edge, then `bcd` returns to 4'hF on the following edge.
- Rescan in SHOW: the new window starts at the recapture edge and lasts a full HOLD_CYCLES.
- `clear_p` in SHOW: blank at edge N+3 relative to the clear key going low.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use HOLD_CYCLES=8 and CNT_W=8.

- Reset, then idle 10 cycles: `bcd` = 4'hF, `showing` = 0, `scan_count` = 0 every cycle.
- `upc_sw` = 4'h3, press `scan_key` at edge N and hold for 20 cycles:
  - `bcd` = 4'h3 and `showing` = 1 from edge N+3 through 8 cycles.
  - `bcd` = 4'hF after that.
  - `scan_count` = 1; no retrigger while the key is held.
- `upc_sw` = 4'h2 scan: `unknown` = 1, `bcd` = 4'h2, `scan_count` unchanged. Then `upc_sw` = 4'h6 rescan at window cycle 5: `bcd` = 4'h6, `unknown` = 0, `showing` lasts 8 cycles from recapture, `scan_count` +1.
- Scan 4'h4, then press `clear_key` at window cycle 2: blank 3 cycles after the press. `scan_key` and `clear_key` pressed in the same cycle while in IDLE: stays IDLE, no count.
- 260 separate known scans: `scan_count` saturates at 255.
- `reset` asserted mid-window: `bcd` = 4'hF and `scan_count` = 0 on the next edge.
